// File: rtl/alu_op_encoder.sv
// RV32I decode stage producing the ALU Operation code, a tag and an illegal flag.
// Registered output stage with a one-entry skid register isolates fetch from execute backpressure.
module alu_op_encoder #(
    parameter int unsigned TAG_WIDTH = 32,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          instr,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [25:0]          Operation,
    output logic                 out_illegal,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic [CNT_WIDTH-1:0] illegal_cnt
);

    localparam int unsigned OP_WIDTH = 26;

    localparam logic [OP_WIDTH-1:0] OP_OR   = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_ADD  = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_SUB  = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] OP_AND  = OP_WIDTH'(8);
    localparam logic [OP_WIDTH-1:0] OP_XOR  = OP_WIDTH'(16);
    localparam logic [OP_WIDTH-1:0] OP_SLT  = OP_WIDTH'(32);
    localparam logic [OP_WIDTH-1:0] OP_SRAI = OP_WIDTH'(64);
    localparam logic [OP_WIDTH-1:0] OP_SRLI = OP_WIDTH'(128);
    localparam logic [OP_WIDTH-1:0] OP_SLLI = OP_WIDTH'(256);
    localparam logic [OP_WIDTH-1:0] OP_BEQ  = OP_WIDTH'(512);
    localparam logic [OP_WIDTH-1:0] OP_BNE  = OP_WIDTH'(1024);
    localparam logic [OP_WIDTH-1:0] OP_BLT  = OP_WIDTH'(2048);
    localparam logic [OP_WIDTH-1:0] OP_BGE  = OP_WIDTH'(4096);
    localparam logic [OP_WIDTH-1:0] OP_JAL  = OP_WIDTH'(8192);
    localparam logic [OP_WIDTH-1:0] OP_JALR = OP_WIDTH'(16384);
    localparam logic [OP_WIDTH-1:0] OP_LUI  = OP_WIDTH'(32768);
    localparam logic [OP_WIDTH-1:0] OP_LW   = OP_WIDTH'(65536);
    localparam logic [OP_WIDTH-1:0] OP_SW   = OP_WIDTH'(131072);
    localparam logic [OP_WIDTH-1:0] OP_LB   = OP_WIDTH'(262144);
    localparam logic [OP_WIDTH-1:0] OP_LH   = OP_WIDTH'(524288);
    localparam logic [OP_WIDTH-1:0] OP_LBU  = OP_WIDTH'(1048576);
    localparam logic [OP_WIDTH-1:0] OP_SB   = OP_WIDTH'(2097152);
    localparam logic [OP_WIDTH-1:0] OP_SH   = OP_WIDTH'(4194304);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    typedef struct packed {
        logic [OP_WIDTH-1:0]  op;
        logic                 illegal;
        logic [TAG_WIDTH-1:0] tag;
    } entry_t;

    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [OP_WIDTH-1:0] dec_op;
    entry_t              dec_entry;
    entry_t              out_q;
    entry_t              skid_q;
    logic [1:0]          state_q;
    logic [1:0]          state_d;
    logic                accept;
    logic                handshake;
    logic                load_out_in;
    logic                load_out_skid;
    logic                load_skid;
    logic                unused_instr_bits;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

    // Instruction decode; every legal code is non-zero, so zero marks illegal
    always_comb begin
        dec_op = '0;
        case (opcode)
            7'b0110011: begin
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000:  dec_op = OP_ADD;
                        3'b110:  dec_op = OP_OR;
                        3'b111:  dec_op = OP_AND;
                        3'b100:  dec_op = OP_XOR;
                        3'b010:  dec_op = OP_SLT;
                        default: dec_op = '0;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec_op = OP_SUB;
                end
            end
            7'b0010011: begin
                case (funct3)
                    3'b000:  dec_op = OP_ADD;
                    3'b110:  dec_op = OP_OR;
                    3'b111:  dec_op = OP_AND;
                    3'b100:  dec_op = OP_XOR;
                    3'b010:  dec_op = OP_SLT;
                    3'b001:  dec_op = (funct7 == 7'b0000000) ? OP_SLLI : '0;
                    3'b101: begin
                        if (funct7 == 7'b0000000)      dec_op = OP_SRLI;
                        else if (funct7 == 7'b0100000) dec_op = OP_SRAI;
                    end
                    default: dec_op = '0;
                endcase
            end
            7'b1100011: begin
                case (funct3)
                    3'b000:  dec_op = OP_BEQ;
                    3'b001:  dec_op = OP_BNE;
                    3'b100:  dec_op = OP_BLT;
                    3'b101:  dec_op = OP_BGE;
                    default: dec_op = '0;
                endcase
            end
            7'b1101111: dec_op = OP_JAL;
            7'b1100111: dec_op = (funct3 == 3'b000) ? OP_JALR : '0;
            7'b0110111: dec_op = OP_LUI;
            7'b0000011: begin
                case (funct3)
                    3'b000:  dec_op = OP_LB;
                    3'b001:  dec_op = OP_LH;
                    3'b010:  dec_op = OP_LW;
                    3'b100:  dec_op = OP_LBU;
                    default: dec_op = '0;
                endcase
            end
            7'b0100011: begin
                case (funct3)
                    3'b000:  dec_op = OP_SB;
                    3'b001:  dec_op = OP_SH;
                    3'b010:  dec_op = OP_SW;
                    default: dec_op = '0;
                endcase
            end
            default: dec_op = '0;
        endcase
    end

    assign dec_entry = '{op: dec_op, illegal: ~|dec_op, tag: in_tag};

    assign accept    = in_valid && in_ready && !flush;
    assign handshake = out_valid && out_ready;

    // Occupancy next-state and register load selects
    always_comb begin
        state_d       = state_q;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                load_out_in = accept;
                if (accept) state_d = ST_ONE;
            end
            ST_ONE: begin
                load_out_in = accept && handshake;
                load_skid   = accept && !handshake;
                if (accept && !handshake)      state_d = ST_TWO;
                else if (handshake && !accept) state_d = ST_EMPTY;
            end
            ST_TWO: begin
                load_out_skid = handshake;
                if (handshake) state_d = ST_ONE;
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) state_d = ST_EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d != ST_TWO);
            out_valid <= (state_d != ST_EMPTY);
        end
    end

    // Payload registers; SKID only advances into OUT on the handshake edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (load_out_in)        out_q <= dec_entry;
            else if (load_out_skid) out_q <= skid_q;
            if (load_skid)          skid_q <= dec_entry;
        end
    end

    // Saturating count of delivered illegal instructions, kept across flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt <= '0;
        end else if (handshake && out_q.illegal && (illegal_cnt != '1)) begin
            illegal_cnt <= illegal_cnt + CNT_WIDTH'(1);
        end
    end

    assign Operation   = out_q.op;
    assign out_illegal = out_q.illegal;
    assign out_tag     = out_q.tag;

endmodule

// File: tb/tb_alu_op_encoder.sv
// Bench for alu_op_encoder: table of decode vectors plus a FIFO scoreboard
// that predicts handshake, occupancy, payload and illegal counter every cycle.
module tb_alu_op_encoder;

    localparam int unsigned TAG_WIDTH = 32;
    localparam int unsigned CNT_WIDTH = 8;
    localparam int          NV        = 22;
    localparam int          CNT_MAX   = 255;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          instr;
    logic [TAG_WIDTH-1:0] in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [25:0]          Operation;
    logic                 out_illegal;
    logic [TAG_WIDTH-1:0] out_tag;
    logic [CNT_WIDTH-1:0] illegal_cnt;

    alu_op_encoder #(.TAG_WIDTH(TAG_WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .Operation(Operation),
        .out_illegal(out_illegal), .out_tag(out_tag), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [25:0] op;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [25:0]          op;
        logic                 ill;
        logic [TAG_WIDTH-1:0] tag;
    } exp_t;

    vec_t        vecs[NV];
    exp_t        q[$];
    int          checks;
    int          errors;
    int          model_cnt;
    logic [25:0] cur_op;
    logic        cur_ill;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called just after a falling edge with inputs already driven; advances one clock
    task automatic cycle(output bit acc);
        bit exp_rdy;
        bit exp_ov;
        bit hs;
        exp_rdy = (q.size() < 2);
        exp_ov  = (q.size() > 0);
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        chk("out_valid", 64'(out_valid), 64'(exp_ov));
        chk("illegal_cnt", 64'(illegal_cnt), 64'(model_cnt));
        if (exp_ov && out_valid) begin
            chk("operation", 64'(Operation), 64'(q[0].op));
            chk("out_illegal", 64'(out_illegal), 64'(q[0].ill));
            chk("out_tag", 64'(out_tag), 64'(q[0].tag));
        end
        hs  = exp_ov && out_ready;
        acc = in_valid && exp_rdy && !flush;
        if (hs) begin
            if (q[0].ill && model_cnt < CNT_MAX) model_cnt++;
            void'(q.pop_front());
        end
        if (flush) q.delete();
        else if (acc) q.push_back('{cur_op, cur_ill, in_tag});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_vec(input int i);
        instr   = vecs[i].instr;
        cur_op  = vecs[i].op;
        cur_ill = vecs[i].ill;
    endtask

    task automatic pick(input bit ill_only);
        if (ill_only) begin
            instr   = {25'($urandom), 7'h7F};
            cur_op  = '0;
            cur_ill = 1'b1;
        end else begin
            set_vec(int'($urandom_range(NV - 1)));
        end
    endtask

    // Offer n instructions, holding each until accepted; flush is raised once at flush_at
    task automatic send(input int n, input logic [31:0] tag0, input int ready_pct,
                        input bit ill_only, input int flush_at);
        int sent   = 0;
        int budget = n * 20 + 50;
        bit acc;
        bit flushed;
        pick(ill_only);
        while (sent < n && budget > 0) begin
            in_valid  = 1'b1;
            in_tag    = tag0 + 32'(sent);
            out_ready = (int'($urandom_range(99)) < ready_pct);
            flushed   = (sent == flush_at);
            flush     = flushed;
            cycle(acc);
            flush = 1'b0;
            if (acc || flushed) begin
                sent++;
                pick(ill_only);
            end
            budget--;
        end
        in_valid = 1'b0;
        chk("send_done", 64'(sent), 64'(n));
    endtask

    task automatic drain();
        int budget = 10;
        bit acc;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (q.size() > 0 && budget > 0) begin
            cycle(acc);
            budget--;
        end
        cycle(acc);
        chk("drain_idle", 64'(out_valid), 64'(0));
    endtask

    initial begin
        bit acc;
        int guard;
        checks = 0; errors = 0; model_cnt = 0;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; in_tag = '0; cur_op = '0; cur_ill = 1'b0;

        vecs[0]  = '{32'h002081B3, 26'd2,       1'b0};  // ADD
        vecs[1]  = '{32'h402081B3, 26'd6,       1'b0};  // SUB
        vecs[2]  = '{32'h4020D193, 26'd64,      1'b0};  // SRAI
        vecs[3]  = '{32'h0020D463, 26'd4096,    1'b0};  // BGE
        vecs[4]  = '{32'h00209023, 26'd4194304, 1'b0};  // SH
        vecs[5]  = '{32'h0000007F, 26'd0,       1'b1};  // unknown opcode
        vecs[6]  = '{32'h0020E1B3, 26'd1,       1'b0};  // OR
        vecs[7]  = '{32'h002091B3, 26'd0,       1'b1};  // R-type f3=001
        vecs[8]  = '{32'h4020F1B3, 26'd0,       1'b1};  // f7=0100000 f3=111
        vecs[9]  = '{32'h0020C193, 26'd16,      1'b0};  // XORI
        vecs[10] = '{32'h00209193, 26'd256,     1'b0};  // SLLI
        vecs[11] = '{32'h40209193, 26'd0,       1'b1};  // SLLI bad funct7
        vecs[12] = '{32'h0000006F, 26'd8192,    1'b0};  // JAL
        vecs[13] = '{32'h00000067, 26'd16384,   1'b0};  // JALR
        vecs[14] = '{32'h00001067, 26'd0,       1'b1};  // JALR f3=001
        vecs[15] = '{32'h00000037, 26'd32768,   1'b0};  // LUI
        vecs[16] = '{32'h00002003, 26'd65536,   1'b0};  // LW
        vecs[17] = '{32'h00004003, 26'd1048576, 1'b0};  // LBU
        vecs[18] = '{32'h00003003, 26'd0,       1'b1};  // load f3=011
        vecs[19] = '{32'h00002023, 26'd131072,  1'b0};  // SW
        vecs[20] = '{32'h00000063, 26'd512,     1'b0};  // BEQ
        vecs[21] = '{32'h00002063, 26'd0,       1'b1};  // branch f3=010

        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_operation", 64'(Operation), 64'(0));
        chk("rst_out_illegal", 64'(out_illegal), 64'(0));
        chk("rst_out_tag", 64'(out_tag), 64'(0));
        chk("rst_illegal_cnt", 64'(illegal_cnt), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Decode table, one per cycle with the sink always ready
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            in_valid = 1'b1;
            in_tag   = 32'(i);
            set_vec(i);
            cycle(acc);
        end
        drain();

        // Back-to-back streaming
        send(100, 32'h0000_1000, 100, 1'b0, -1);
        drain();

        // Backpressure: third offer must stall, then drain in order
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_vec(0); in_tag = 32'h100; cycle(acc);
        set_vec(3); in_tag = 32'h101; cycle(acc);
        set_vec(5); in_tag = 32'h102; cycle(acc);
        chk("bp_in_ready_low", 64'(in_ready), 64'(0));
        cycle(acc);
        out_ready = 1'b1;
        guard = 0;
        acc   = 1'b0;
        while (!acc && guard < 10) begin
            cycle(acc);
            guard++;
        end
        chk("bp_third_accepted", 64'(acc), 64'(1));
        drain();

        // Flush with two held and a new word offered in the flush cycle
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_vec(1); in_tag = 32'h200; cycle(acc);
        set_vec(2); in_tag = 32'h201; cycle(acc);
        set_vec(4); in_tag = 32'h202; flush = 1'b1; cycle(acc);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'(0));
        chk("flush_in_ready", 64'(in_ready), 64'(1));
        send(5, 32'h0000_0300, 100, 1'b0, -1);
        drain();

        // Random backpressure
        send(100, 32'h0000_2000, 60, 1'b0, -1);
        drain();

        // Counter saturation with a flush in the middle
        send(300, 32'h0000_4000, 100, 1'b1, 150);
        drain();
        chk("cnt_saturated", 64'(illegal_cnt), 64'(CNT_MAX));

        // Asynchronous reset with two entries held
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_vec(6); in_tag = 32'h500; cycle(acc);
        set_vec(9); in_tag = 32'h501; cycle(acc);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 64'(in_ready), 64'(1));
        chk("arst_out_valid", 64'(out_valid), 64'(0));
        chk("arst_operation", 64'(Operation), 64'(0));
        chk("arst_out_illegal", 64'(out_illegal), 64'(0));
        chk("arst_out_tag", 64'(out_tag), 64'(0));
        chk("arst_illegal_cnt", 64'(illegal_cnt), 64'(0));
        q.delete();
        model_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(acc);
        send(5, 32'h0000_0600, 100, 1'b0, -1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_op_encoder.md
# alu_op_encoder

Decode-side producer of the 26-bit ALU `Operation` code.
- Accepts 32-bit RV32I instruction words over a valid/ready handshake and decodes opcode/funct3/funct7 into the team's `Operation` encoding.
- Delivers the code, a tag and an illegal flag through a registered output stage with a 2-entry skid buffer, so backpressure from the execute stage never combinationally reaches fetch.
- Sits between instruction fetch and the ALU/execute stage.

## Interface
- `TAG_WIDTH`, 32: width of the sideband tag (PC) carried alongside each instruction.
- `CNT_WIDTH`, 8: width of the saturating illegal-instruction counter.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous pipeline flush; drops every held and incoming entry.
- `in_valid`  in  1  `instr`/`in_tag` are valid.
- `in_ready`  out  1  block can accept; driven directly from a flop.
- `instr`  in  32  RV32I instruction word.
- `in_tag`  in  TAG_WIDTH  sideband carried unchanged to the output.
- `out_valid`  out  1  `Operation`/`out_tag`/`out_illegal` are valid.
- `out_ready`  in  1  execute stage accepts.
- `Operation`  out  26  ALU operation code.
- `out_illegal`  out  1  instruction did not decode; `Operation` = 0.
- `out_tag`  out  TAG_WIDTH  tag of the presented entry.
- `illegal_cnt`  out  CNT_WIDTH  saturating count of illegal instructions delivered.

## Operation
- **Encoding:** `Operation` values, decimal.
  - OR=1, ADD=2, SUB=6, AND=8, XOR=16, SLT=32.
  - SRAI=64, SRLI=128, SLLI=256.
  - BEQ=512, BNE=1024, BLT=2048, BGE=4096.
  - JAL=8192, JALR=16384, LUI=32768.
  - LW=65536, SW=131072, LB=262144, LH=524288, LBU=1048576, SB=2097152, SH=4194304.
  - Bits 25:23 are never set.
- **Decode, opcode `0110011` (R-type):**
  - funct7=0: f3 000→ADD, 110→OR, 111→AND, 100→XOR, 010→SLT.
  - f3=000 with funct7=`0100000` → SUB.
  - Anything else → illegal.
- **Decode, opcode `0010011` (I-type ALU):**
  - f3 000→ADD, 110→OR, 111→AND, 100→XOR, 010→SLT.
  - f3=001 with funct7=0 → SLLI.
  - f3=101 with funct7=0 → SRLI; with funct7=`0100000` → SRAI.
  - Other shift funct7 → illegal.
- **Decode, other opcodes:**
  - `1100011`: f3 000→BEQ, 001→BNE, 100→BLT, 101→BGE; else illegal.
  - `1101111` → JAL.
  - `1100111` with f3=000 → JALR; other f3 → illegal.
  - `0110111` → LUI.
  - `0000011`: f3 000→LB, 001→LH, 010→LW, 100→LBU; else illegal.
  - `0100011`: f3 000→SB, 001→SH, 010→SW; else illegal.
  - Any other opcode → illegal, `Operation`=0.
- **Storage:** output register (OUT) plus one skid register (SKID). Each holds `{Operation, illegal, tag}` and a valid bit.
- **Occupancy states:**
  - EMPTY → ONE on accept.
  - ONE → TWO on accept without output handshake.
  - TWO → ONE on output handshake.
  - ONE → EMPTY on output handshake without accept.
  - ONE stays ONE on simultaneous accept + handshake.
- `in_ready` = occupancy ≠ TWO, registered. `out_valid` = OUT valid.
- Accept = `in_valid && in_ready`. Output handshake = `out_valid && out_ready`.
- Ordering is strictly FIFO. SKID moves into OUT on the handshake edge, never ahead of it.
- `illegal_cnt` increments on each output handshake with `out_illegal`=1 and saturates at 2^CNT_WIDTH−1. Flush does not clear it.
- **Flush:**
  - At the next edge both valid bits clear, `in_ready`=1, and an input presented in the flush cycle is discarded.
  - An output handshake in the flush cycle still counts toward `illegal_cnt`.
  - Flush has priority over accept.

## Timing
- **Reset values:**
  - `in_ready`=1, `out_valid`=0, `Operation`=0, `out_illegal`=0.
  - `out_tag`=0, `illegal_cnt`=0, SKID cleared.
- Reset asserts asynchronously at any point, including mid-transfer; all entries are lost.
- Latency: an accept at edge N gives `out_valid`=1 after edge N with decoded fields, when occupancy was EMPTY or OUT handshook at N.
- Throughput: 1 instruction/cycle with `out_ready` held high.
- While `out_valid`=1 and `out_ready`=0, `Operation`, `out_illegal` and `out_tag` stay bit-stable.
- `in_ready` falls the cycle after the second entry is accepted and rises the cycle after an output handshake from TWO.

## Test plan
- **Reset:** pulse `rst_n` low mid-stream with TWO entries held → outputs return to reset values asynchronously; `in_ready`=1 after release.
- **Decode sweep:** ADD `0x002081B3` → 2; SUB `0x402081B3` → 6; SRAI `0x4020D193` → 64; BGE `0x0020D463` → 4096; SH `0x00209023` → 4194304; opcode `0x7F` → 0 with `out_illegal`=1.
- **Streaming:** 100 back-to-back instructions with `out_ready`=1 → one output per cycle, 1-cycle latency, tags in order.
- **Backpressure:**
  - `out_ready`=0 while 3 instructions are offered → two accepted, `in_ready`=0 from the third cycle, outputs stable.
  - Release → tags drain in order.
- **Flush:**
  - Assert `flush` with TWO entries and `in_valid`=1 → next cycle `out_valid`=0, `in_ready`=1.
  - Flushed tags never appear at the output.
- **Counter:** with CNT_WIDTH=8, deliver 300 illegal words → `illegal_cnt` stops at 255; a flush mid-sequence does not reset it.
